// File: rtl/frame_update_scheduler_pkg.sv
// ============================================================================
// frame_update_scheduler_pkg
// Shared types and constants for the per-frame object update scheduler.
// Rev 1.0
// ============================================================================
`default_nettype none

package frame_update_scheduler_pkg;

  localparam int NUM_OBJ_DEFAULT = 4;
  localparam int OBJ_ID_W        = 2;
  localparam int KEYCODE_W       = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/frame_update_scheduler_if.sv
// ============================================================================
// frame_update_scheduler_if
// Frame-control, update-datapath handshake and status bundle of the scheduler.
// Rev 1.0
// ============================================================================
`default_nettype none

interface frame_update_scheduler_if
  import frame_update_scheduler_pkg::*;
#(
  parameter int NUM_OBJ = NUM_OBJ_DEFAULT,
  parameter int IDW     = OBJ_ID_W
);

  logic                 vsync;
  logic                 enable;
  logic [NUM_OBJ-1:0]   obj_active;
  logic [KEYCODE_W-1:0] keycode;
  logic [KEYCODE_W-1:0] keycode_frame;
  logic                 upd_req;
  logic [IDW-1:0]       upd_id;
  logic                 upd_ack;
  logic                 upd_hit;
  logic [NUM_OBJ-1:0]   hit_mask;
  logic                 frame_done;
  logic                 busy;
  logic [15:0]          frame_cnt;
  logic                 overrun_err;
  logic                 timeout_err;
  logic                 clr_err;

  modport slave (
    input  vsync, enable, obj_active, keycode, upd_ack, upd_hit, clr_err,
    output keycode_frame, upd_req, upd_id, hit_mask, frame_done, busy,
           frame_cnt, overrun_err, timeout_err
  );

  modport master (
    output vsync, enable, obj_active, keycode, upd_ack, upd_hit, clr_err,
    input  keycode_frame, upd_req, upd_id, hit_mask, frame_done, busy,
           frame_cnt, overrun_err, timeout_err
  );

endinterface

`default_nettype wire

// File: rtl/frame_update_scheduler_obj_prio_enc.sv
// ============================================================================
// obj_prio_enc
// Lowest-set-bit encoder: object 0 has the highest update priority.
// Rev 1.0
// ============================================================================
`default_nettype none

module obj_prio_enc #(
  parameter int NUM_OBJ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_OBJ-1:0] req_i,
  output logic               valid_o,
  output logic [IDW-1:0]     id_o
);

  always_comb begin
    valid_o = |req_i;
    id_o    = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = IDW'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/frame_update_scheduler.sv
// ============================================================================
// frame_update_scheduler
// Per-frame sequencer granting a shared move/collision datapath to each active object.
// Rev 1.0
// ============================================================================
`default_nettype none

module frame_update_scheduler
  import frame_update_scheduler_pkg::*;
#(
  parameter int NUM_OBJ = NUM_OBJ_DEFAULT,
  parameter int IDW     = $clog2(NUM_OBJ),
  parameter int TIMEOUT = 1023
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  frame_update_scheduler_if.slave  bus
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  sched_state_t         state_q, state_d;
  logic                 vs_q;
  logic [NUM_OBJ-1:0]   pending_q, pending_d;
  logic [NUM_OBJ-1:0]   hit_acc_q, hit_acc_d;
  logic [WCW-1:0]       wait_cnt_q, wait_cnt_d;
  logic [KEYCODE_W-1:0] keycode_frame_q, keycode_frame_d;
  logic                 upd_req_q, upd_req_d;
  logic [IDW-1:0]       upd_id_q, upd_id_d;
  logic [NUM_OBJ-1:0]   hit_mask_q, hit_mask_d;
  logic                 frame_done_q, frame_done_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic                 overrun_q, overrun_d;
  logic                 timeout_q, timeout_d;

  logic                 vs_rise;
  logic                 tmo_set;
  logic                 ovr_set;
  logic                 pend_valid;
  logic [IDW-1:0]       pend_id;

  obj_prio_enc #(
    .NUM_OBJ (NUM_OBJ),
    .IDW     (IDW)
  ) u_prio_enc (
    .req_i   (pending_q),
    .valid_o (pend_valid),
    .id_o    (pend_id)
  );

  assign vs_rise = bus.vsync & ~vs_q;

  always_comb begin
    state_d         = state_q;
    pending_d       = pending_q;
    hit_acc_d       = hit_acc_q;
    wait_cnt_d      = wait_cnt_q;
    keycode_frame_d = keycode_frame_q;
    upd_req_d       = upd_req_q;
    upd_id_d        = upd_id_q;
    hit_mask_d      = hit_mask_q;
    frame_done_d    = 1'b0;
    frame_cnt_d     = frame_cnt_q;
    tmo_set         = 1'b0;

    case (state_q)
      IDLE: begin
        if (vs_rise && bus.enable) begin
          keycode_frame_d = bus.keycode;
          pending_d       = bus.obj_active;
          hit_acc_d       = '0;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        if (pend_valid) begin
          upd_id_d   = pend_id;
          upd_req_d  = 1'b1;
          wait_cnt_d = '0;
          state_d    = WAIT;
        end else begin
          state_d = DONE;
        end
      end
      WAIT: begin
        if (bus.upd_ack) begin
          hit_acc_d[upd_id_q] = bus.upd_hit;
          pending_d[upd_id_q] = 1'b0;
          upd_req_d           = 1'b0;
          state_d             = ISSUE;
        end else if (wait_cnt_q == WCW'(TIMEOUT)) begin
          // Abandon the object; its hit bit stays clear for this frame.
          tmo_set             = 1'b1;
          pending_d[upd_id_q] = 1'b0;
          upd_req_d           = 1'b0;
          state_d             = ISSUE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      DONE: begin
        hit_mask_d   = hit_acc_q;
        frame_done_d = 1'b1;
        frame_cnt_d  = frame_cnt_q + 16'd1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Error set takes priority over a simultaneous clear.
    ovr_set   = vs_rise && (state_q != IDLE);
    overrun_d = ovr_set | (overrun_q & ~bus.clr_err);
    timeout_d = tmo_set | (timeout_q & ~bus.clr_err);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q         <= IDLE;
      vs_q            <= 1'b0;
      pending_q       <= '0;
      hit_acc_q       <= '0;
      wait_cnt_q      <= '0;
      keycode_frame_q <= '0;
      upd_req_q       <= 1'b0;
      upd_id_q        <= '0;
      hit_mask_q      <= '0;
      frame_done_q    <= 1'b0;
      frame_cnt_q     <= '0;
      overrun_q       <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      vs_q            <= bus.vsync;
      pending_q       <= pending_d;
      hit_acc_q       <= hit_acc_d;
      wait_cnt_q      <= wait_cnt_d;
      keycode_frame_q <= keycode_frame_d;
      upd_req_q       <= upd_req_d;
      upd_id_q        <= upd_id_d;
      hit_mask_q      <= hit_mask_d;
      frame_done_q    <= frame_done_d;
      frame_cnt_q     <= frame_cnt_d;
      overrun_q       <= overrun_d;
      timeout_q       <= timeout_d;
    end
  end

  assign bus.keycode_frame = keycode_frame_q;
  assign bus.upd_req       = upd_req_q;
  assign bus.upd_id        = upd_id_q;
  assign bus.hit_mask      = hit_mask_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.frame_cnt     = frame_cnt_q;
  assign bus.overrun_err   = overrun_q;
  assign bus.timeout_err   = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_update_scheduler.sv
// ============================================================================
// tb_frame_update_scheduler
// Randomized frames checked against a frame-level reference model of the scheduler.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_frame_update_scheduler;

  localparam int TMO = 1023;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_errs;

  // Frame-level reference state
  logic [15:0] m_cnt;
  logic [3:0]  m_mask;
  logic [15:0] m_key;
  logic        m_ovr;
  logic        m_tmo;

  frame_update_scheduler_if #(.NUM_OBJ(4), .IDW(2)) bus ();

  frame_update_scheduler #(
    .NUM_OBJ (4),
    .IDW     (2),
    .TIMEOUT (TMO)
  ) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge and retire single-cycle input pulses.
  task automatic step();
    @(negedge clk);
    bus.vsync   = 1'b0;
    bus.upd_ack = 1'b0;
    bus.upd_hit = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_hit_mask"}, 64'(bus.hit_mask), 64'(m_mask));
    check({tag, "_frame_cnt"}, 64'(bus.frame_cnt), 64'(m_cnt));
    check({tag, "_keycode"}, 64'(bus.keycode_frame), 64'(m_key));
    check({tag, "_overrun"}, 64'(bus.overrun_err), 64'(m_ovr));
    check({tag, "_timeout"}, 64'(bus.timeout_err), 64'(m_tmo));
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {bus.keycode_frame, bus.upd_req, bus.upd_id, bus.hit_mask, bus.frame_done,
                bus.busy, bus.frame_cnt, bus.overrun_err, bus.timeout_err}, 64'd0);
  endtask

  // One whole frame. lat<0 picks a random ack latency per object; noack bits
  // are never acknowledged; ovr fires a second vsync (with clr_err) during the first wait.
  task automatic run_frame(input logic [3:0] act, input logic [15:0] key, input int lat,
                           input logic [3:0] hits, input logic [3:0] noack,
                           input bit ovr, input bit scramble);
    logic [3:0] exp_mask;
    int  n;
    int  hi;
    int  l;
    bit  first;
    exp_mask       = '0;
    first          = 1'b1;
    bus.enable     = 1'b1;
    bus.obj_active = act;
    bus.keycode    = key;
    step();
    bus.vsync = 1'b1;
    step();
    if (scramble) begin
      bus.obj_active = 4'($urandom);
      bus.keycode    = 16'($urandom);
      bus.enable     = 1'($urandom);
    end
    check("busy_start", 64'(bus.busy), 64'd1);
    n = 1;
    for (int id = 0; id < 4; id++) begin
      if (act[id]) begin
        while (!bus.upd_req && n < 8) begin
          step();
          n++;
        end
        check("req_latency", 64'(n), first ? 64'd2 : 64'd1);
        check("upd_id", 64'(bus.upd_id), 64'(id));
        if (ovr && first) begin
          bus.vsync   = 1'b1;
          bus.clr_err = 1'b1;
          m_ovr       = 1'b1;
          m_tmo       = 1'b0;
        end
        first = 1'b0;
        if (noack[id]) begin
          hi = 1;
          step();
          while (bus.upd_req && hi < TMO + 8) begin
            hi++;
            step();
          end
          check("timeout_req_cycles", 64'(hi), 64'(TMO + 1));
          m_tmo = 1'b1;
        end else begin
          l = (lat < 0) ? int'($urandom_range(0, 4)) : lat;
          for (int j = 0; j < l; j++) begin
            step();
            check("req_hold", {61'd0, bus.upd_req, bus.upd_id}, {61'd0, 1'b1, 2'(id)});
          end
          bus.upd_ack = 1'b1;
          bus.upd_hit = hits[id];
          exp_mask[id] = hits[id];
          step();
          check("req_drop", 64'(bus.upd_req), 64'd0);
        end
        n = 0;
      end
    end
    while (!bus.frame_done && n < 8) begin
      step();
      n++;
    end
    check("done_latency", 64'(n), (act == 4'd0) ? 64'd3 : 64'd2);
    m_cnt  = m_cnt + 16'd1;
    m_mask = exp_mask;
    m_key  = key;
    check("busy_end", 64'(bus.busy), 64'd0);
    check_status("frame");
    step();
    check("done_pulse", 64'(bus.frame_done), 64'd0);
    bus.enable = 1'b1;
  endtask

  initial begin
    logic [3:0] act;
    logic [3:0] noack;
    bit         ovr;
    n_checks       = 0;
    n_errs         = 0;
    m_cnt          = '0;
    m_mask         = '0;
    m_key          = '0;
    m_ovr          = 1'b0;
    m_tmo          = 1'b0;
    rst_n          = 1'b0;
    bus.vsync      = 1'b0;
    bus.enable     = 1'b1;
    bus.obj_active = '0;
    bus.keycode    = '0;
    bus.upd_ack    = 1'b0;
    bus.upd_hit    = 1'b0;
    bus.clr_err    = 1'b0;

    repeat (3) step();
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (2) step();

    // Directed frame: three objects, ack after 3 cycles, only id 3 hits
    run_frame(4'b1011, 16'h001A, 3, 4'b1000, 4'b0000, 1'b0, 1'b0);
    check("dir_hit_mask", 64'(bus.hit_mask), 64'h8);
    check("dir_frame_cnt", 64'(bus.frame_cnt), 64'd1);

    // Asynchronous reset while an object is waiting for ack
    bus.obj_active = 4'b0001;
    step();
    bus.vsync = 1'b1;
    step();
    step();
    check("mid_wait_req", 64'(bus.upd_req), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset_outputs");
    step();
    step();
    rst_n  = 1'b1;
    m_cnt  = '0;
    m_mask = '0;
    m_key  = '0;
    m_ovr  = 1'b0;
    m_tmo  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_reset_idle", {62'd0, bus.upd_req, bus.busy}, 64'd0);
    end

    // Empty mask
    run_frame(4'b0000, 16'h0BEE, 0, 4'b1111, 4'b0000, 1'b0, 1'b0);
    check("empty_hit_mask", 64'(bus.hit_mask), 64'd0);

    // Id 1 never acknowledged
    run_frame(4'b0011, 16'h1234, 1, 4'b0011, 4'b0010, 1'b0, 1'b0);
    check("tmo_hit_mask", 64'(bus.hit_mask), 64'h1);
    check("tmo_err", 64'(bus.timeout_err), 64'd1);
    bus.clr_err = 1'b1;
    step();
    m_tmo = 1'b0;
    check("tmo_cleared", 64'(bus.timeout_err), 64'd0);

    // Second vsync during WAIT, with a clear in the same cycle
    run_frame(4'b0110, 16'h5A5A, 2, 4'b0100, 4'b0000, 1'b1, 1'b0);
    check("ovr_err", 64'(bus.overrun_err), 64'd1);
    bus.clr_err = 1'b1;
    step();
    m_ovr = 1'b0;
    check("ovr_cleared", 64'(bus.overrun_err), 64'd0);

    // Paused: frame edge ignored
    bus.enable     = 1'b0;
    bus.obj_active = 4'b1111;
    bus.keycode    = 16'hDEAD;
    step();
    bus.vsync = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("paused_idle", {62'd0, bus.upd_req, bus.busy}, 64'd0);
    end
    check_status("paused");
    bus.enable = 1'b1;

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      act   = 4'($urandom);
      noack = ($urandom_range(0, 9) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      ovr   = ($urandom_range(0, 5) == 0);
      run_frame(act, 16'($urandom), -1, 4'($urandom), noack, ovr, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        bus.clr_err = 1'b1;
        step();
        m_ovr = 1'b0;
        m_tmo = 1'b0;
        check_status("clr");
      end
    end

    // Frame counter wrap
    step();
    dut.frame_cnt_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    step();
    run_frame(4'b0101, 16'h00FF, 0, 4'b0001, 4'b0000, 1'b0, 1'b0);
    check("wrap_frame_cnt", 64'(bus.frame_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
